frame_parser_param: RTL
=======================

# frame_parser_param

Parametrised byte-stream frame parser and the successor to the fixed-format message identifier. It hunts for the 0x55 0xD5 preamble, then classifies the frame as a control frame (fixed payload length) or a data frame (16-bit length field). It forwards the payload as a registered byte stream with sop/eop/vld framing, flags illegal lengths, and counts completed frames. It sits directly behind the serial-to-byte front end and feeds the downstream frame consumers.

## Interface
- CTRL_LEN, 64: payload bytes in a control frame (1..65535)
- FCS_LEN, 4: trailer bytes after every payload (1..15)
- MIN_LEN, 1: smallest legal data-frame length
- MAX_LEN, 1500: largest legal data-frame length
- CNT_W, 16: width of frame_cnt

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- din  in  8  input byte
- din_vld  in  1  din valid this cycle; when low, the cycle is ignored (parser stalls)
- dout  out  8  forwarded byte
- dout_vld  out  1  dout valid
- dout_sop  out  1  first payload byte of a frame
- dout_eop  out  1  last forwarded byte of a frame
- dout_type  out  1  0 = control, 1 = data; stable from sop through eop
- err  out  1  one-cycle pulse on an illegal length field
- frame_cnt  out  CNT_W  number of completed frames; wraps at 2^CNT_W

## Operation
- State machine: HUNT, SYNC, TYPE, LEN_H, LEN_L, PAY, FCS. All transitions happen only on cycles with din_vld=1.
- HUNT:
  - din=0x55 goes to SYNC.
  - Any other byte stays in HUNT.
- SYNC:
  - 0xD5 goes to TYPE.
  - 0x55 stays in SYNC.
  - Any other byte goes to HUNT.
- TYPE:
  - 0x00 loads remaining count with CTRL_LEN, sets type=0, and goes to PAY.
  - 0xD5 sets type=1 and goes to LEN_H.
  - Any other byte goes to HUNT silently, with no err.
- LEN_H: captures the high byte. LEN_L then captures the low byte, big-endian.
  - If the length L satisfies MIN_LEN ≤ L ≤ MAX_LEN: load remaining=L and go to PAY.
  - Otherwise: pulse err and go to HUNT.
- PAY: forwards each byte.
  - sop is asserted on the first payload byte.
  - When remaining reaches 1, load the FCS counter with FCS_LEN and go to FCS.
- FCS: consumes FCS_LEN bytes, then goes to HUNT.
  - frame_cnt increments with the eop beat.
  - The FCS is not checked.
- Preamble bytes appearing inside PAY or FCS are treated as data; there is no resynchronisation.
- The length counter is 16 bits wide. CTRL_LEN and L are never zero in PAY.
- A new preamble is accepted on the byte immediately after the last FCS byte, so back-to-back frames need no gap.

## Timing
- All outputs are registered. A byte accepted at edge N appears on dout/dout_vld at edge N+1, so latency is 1 cycle.
- dout_vld follows din_vld. It is 0 on stalled cycles, and sop/eop never assert while vld=0.
- When the payload length is 1 and FCS is stripped, sop and eop assert in the same cycle.
- err is asserted the cycle after the accepted LEN_L byte, for one cycle.
- Reset values:
  - dout=0, dout_vld=0, dout_sop=0, dout_eop=0, dout_type=0, err=0, frame_cnt=0.
  - State is HUNT, all counters are 0.
- Reset mid-frame: all outputs go to their reset values at the next edge. No eop is emitted and frame_cnt is not incremented.
- din_vld held low indefinitely freezes the state and counters. There is no timeout.

## Configuration
- FRAME_PARSER_STRIP_FCS_EN defined:
  - FCS bytes are consumed but not forwarded (dout_vld=0).
  - eop is on the last payload byte.
  - frame_cnt increments on that beat.
- Undefined:
  - FCS bytes are forwarded with dout_vld=1.
  - eop is on the last FCS byte.
  - frame_cnt increments there.

## Test plan
- Control frame: 00 45 33 67 24 86 55 D5 00, then 20×0x11, 44×0x22, 4×0xCC.
  - Required: sop on the first 0x11, type=0, and 64 payload beats.
  - eop on the last 0x22 (strip) or on the last 0xCC (no strip).
  - frame_cnt=1.
- Data frame: 20×0x33 55 D5 D5 00 0A, then 5×0xDD, 5×0xEE, 4×0xCC.
  - Required: 10 payload beats with type=1, sop on the first 0xDD.
  - eop on the last 0xEE (strip) or on the last 0xCC (no strip).
- Illegal length: 55 D5 D5 00 00, then 55 D5 D5 05 DD.
  - Required: two err pulses, no dout_vld, frame_cnt unchanged.
- Unknown type and stalls: 55 D5 7E then 00 bytes.
  - Required: no output.
  - Then repeat the data frame with din_vld toggling 1/0 every cycle: identical byte sequence on dout, with vld gaps.
- Back-to-back: two data frames with L=1 and no gap.
  - Required: two sop/eop pairs; with strip, sop=eop in the same cycle; frame_cnt=2.
- Reset mid-frame: deassert rst_n at payload byte 5 of a control frame.
  - Required: all outputs 0 next edge, no eop.
  - A following complete frame parses correctly and frame_cnt=1.

Source files
------------

// File: rtl/frame_parser_param_if.sv
// frame_parser_param_if
//   Byte-stream bus around the frame parser.
//   slave  : parser side (takes din/din_vld, drives the framed output stream)
//   master : feeder/consumer side (drives din/din_vld, observes outputs)
//   Signals: din[7:0], din_vld, dout[7:0], dout_vld, dout_sop, dout_eop,
//            dout_type, err, frame_cnt[CNT_W-1:0]
interface frame_parser_param_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       din;
  logic             din_vld;
  logic [7:0]       dout;
  logic             dout_vld;
  logic             dout_sop;
  logic             dout_eop;
  logic             dout_type;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output din, din_vld,
    input  dout, dout_vld, dout_sop, dout_eop, dout_type, err, frame_cnt
  );

  modport slave (
    input  din, din_vld,
    output dout, dout_vld, dout_sop, dout_eop, dout_type, err, frame_cnt
  );
endinterface

// File: rtl/frame_parser_param.sv
// frame_parser_param
//   Hunts for the 0x55 0xD5 preamble, classifies the frame as control
//   (fixed CTRL_LEN payload) or data (16-bit big-endian length), forwards
//   the payload as a registered byte stream with sop/eop framing, pulses
//   err on an illegal data length and counts completed frames.
//   Ports: clk, rst_n (synchronous, active low), bus (frame_parser_param_if.slave)
//   Build option: FRAME_PARSER_STRIP_FCS_EN -- when defined, trailer bytes
//   are consumed silently and eop lands on the last payload byte; otherwise
//   the trailer is forwarded and eop lands on its last byte.
module frame_parser_param #(
  parameter int CTRL_LEN = 64,
  parameter int FCS_LEN  = 4,
  parameter int MIN_LEN  = 1,
  parameter int MAX_LEN  = 1500,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_parser_param_if.slave bus
);

`ifdef FRAME_PARSER_STRIP_FCS_EN
  localparam bit STRIP_FCS = 1'b1;
`else
  localparam bit STRIP_FCS = 1'b0;
`endif

  typedef enum logic [2:0] {HUNT, SYNC, TYPE, LEN_H, LEN_L, PAY, FCS} state_t;

  state_t           state, state_nx;
  logic [15:0]      rem;
  logic [3:0]       fcs_rem;
  logic [7:0]       len_hi;
  logic             first;     // next PAY byte is the first of the frame

  logic [7:0]       dout_q;
  logic             vld_q, sop_q, eop_q, type_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fwd, sop_nx, eop_nx, err_nx;
  logic [15:0]      len_rx;
  int               len_int;
  logic             len_ok;

  // length is only meaningful while sitting in LEN_L
  assign len_rx  = {len_hi, bus.din};
  assign len_int = int'({16'd0, len_rx});
  assign len_ok  = (len_int >= MIN_LEN) && (len_int <= MAX_LEN);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  // next state; every transition is qualified by din_vld
  always_comb begin
    state_nx = state;
    if (bus.din_vld) begin
      case (state)
        HUNT:  if (bus.din == 8'h55) state_nx = SYNC;
        SYNC:  if (bus.din == 8'hD5)      state_nx = TYPE;
               else if (bus.din != 8'h55) state_nx = HUNT;
        TYPE:  if (bus.din == 8'h00)      state_nx = PAY;
               else if (bus.din == 8'hD5) state_nx = LEN_H;
               else                       state_nx = HUNT;
        LEN_H: state_nx = LEN_L;
        LEN_L: state_nx = len_ok ? PAY : HUNT;
        PAY:   if (rem == 16'd1) state_nx = FCS;
        FCS:   if (fcs_rem == 4'd1) state_nx = HUNT;
        default: state_nx = HUNT;
      endcase
    end
  end

  // output decode: next values of the registered output stream
  always_comb begin
    fwd    = 1'b0;
    sop_nx = 1'b0;
    eop_nx = 1'b0;
    err_nx = 1'b0;
    if (bus.din_vld) begin
      case (state)
        LEN_L: err_nx = !len_ok;
        PAY: begin
          fwd    = 1'b1;
          sop_nx = first;
          eop_nx = STRIP_FCS && (rem == 16'd1);
        end
        FCS: begin
          fwd    = !STRIP_FCS;
          eop_nx = !STRIP_FCS && (fcs_rem == 4'd1);
        end
        default: ;
      endcase
    end
  end

  // counters and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem     <= '0;
      fcs_rem <= '0;
      len_hi  <= '0;
      first   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      type_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q <= fwd;
      sop_q <= sop_nx;
      eop_q <= eop_nx;
      err_q <= err_nx;
      if (fwd)    dout_q <= bus.din;
      if (eop_nx) cnt_q  <= cnt_q + CNT_W'(1);
      if (bus.din_vld) begin
        case (state)
          TYPE: begin
            if (bus.din == 8'h00) begin
              rem    <= 16'(CTRL_LEN);
              type_q <= 1'b0;
              first  <= 1'b1;
            end else if (bus.din == 8'hD5) begin
              type_q <= 1'b1;
            end
          end
          LEN_H: len_hi <= bus.din;
          LEN_L: if (len_ok) begin
            rem   <= len_rx;
            first <= 1'b1;
          end
          PAY: begin
            first <= 1'b0;
            rem   <= rem - 16'd1;
            if (rem == 16'd1) fcs_rem <= 4'(FCS_LEN);
          end
          FCS: fcs_rem <= fcs_rem - 4'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.dout_sop  = sop_q;
  assign bus.dout_eop  = eop_q;
  assign bus.dout_type = type_q;
  assign bus.err       = err_q;
  assign bus.frame_cnt = cnt_q;

endmodule
